// File: rtl/pll_reset_pkg.sv
// Shared definitions for the PLL reset sequencer: FSM state encoding,
// lock-loss counter width and a small elaboration-time helper.
package pll_reset_pkg;

  typedef enum logic [1:0] {
    S_WAIT  = 2'd0,
    S_HOLD  = 2'd1,
    S_STAGE = 2'd2,
    S_RUN   = 2'd3
  } state_e;

  localparam int LOCKLOSS_CNT_W = 8;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pll_reset_sequencer_sync.sv
// sync_ff_chain: STAGES-deep flip-flop synchronizer for a single
// asynchronous level, cleared to 0 by the asynchronous reset.
module sync_ff_chain #(
  parameter int STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  // Shift the raw input one stage deeper each cycle.
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  // Synchronizer flops; cleared asynchronously.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) sync_q <= '0;
    else       sync_q <= sync_d;
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: holds per-domain resets asserted until the PLL lock
// has been stable for HOLD_CYCLES, then releases domain 0, 1, ... N-1 with
// STAGE_GAP cycles between releases. Lock loss or a soft-reset request
// restarts the sequence.
// Optional feature macro: PLL_RESET_SEQ_LOCKLOSS_CNT_EN enables the
// saturating lock-loss event counter; otherwise lock_loss_count reads 0.
//
// Interface note: inputs are plain asynchronous levels; rst_out, ready and
// state_dbg come straight from flops, so there is no handshake and no
// combinational path from any input to any output.
module pll_reset_sequencer
  import pll_reset_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 1024,
  parameter int N_DOMAINS   = 3,
  parameter int STAGE_GAP   = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      pll_locked,
  input  logic                      soft_reset,
  output logic [N_DOMAINS-1:0]      rst_out,
  output logic                      ready,
  output logic [1:0]                state_dbg,
  output logic [LOCKLOSS_CNT_W-1:0] lock_loss_count
);

  localparam int CNT_W = $clog2(max_int(HOLD_CYCLES, STAGE_GAP) + 1);
  localparam int STG_W = (N_DOMAINS > 1) ? $clog2(N_DOMAINS) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);
  localparam logic [STG_W-1:0] STG_LAST  = STG_W'(N_DOMAINS - 1);

  logic locked_s;
  logic soft_s;
  logic soft_req;

  state_e               state_q,     state_d;
  logic [CNT_W-1:0]     cnt_q,       cnt_d;
  logic [STG_W-1:0]     stage_q,     stage_d;
  logic [N_DOMAINS-1:0] rst_out_q,   rst_out_d;
  logic                 ready_q,     ready_d;
  logic                 soft_prev_q, soft_prev_d;

  sync_ff_chain #(.STAGES(SYNC_STAGES)) u_sync_locked (
    .clock (clock),
    .reset (reset),
    .d     (pll_locked),
    .q     (locked_s)
  );

  sync_ff_chain #(.STAGES(SYNC_STAGES)) u_sync_soft (
    .clock (clock),
    .reset (reset),
    .d     (soft_reset),
    .q     (soft_s)
  );

  // A held soft_reset level only restarts the sequence once.
  assign soft_req = soft_s & ~soft_prev_q;

  // Next-state logic: lock loss beats soft request, which beats sequencing.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    stage_d     = stage_q;
    rst_out_d   = rst_out_q;
    ready_d     = ready_q;
    soft_prev_d = soft_s;

    if (state_q == S_WAIT) begin
      rst_out_d = '1;
      ready_d   = 1'b0;
      cnt_d     = '0;
      stage_d   = '0;
      if (locked_s) state_d = S_HOLD;
    end else if (!locked_s) begin
      state_d   = S_WAIT;
      rst_out_d = '1;
      ready_d   = 1'b0;
      cnt_d     = '0;
      stage_d   = '0;
    end else if (soft_req) begin
      state_d   = S_HOLD;
      rst_out_d = '1;
      ready_d   = 1'b0;
      cnt_d     = '0;
      stage_d   = '0;
    end else begin
      case (state_q)
        S_HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            cnt_d     = '0;
            // Domains release in index order, so shifting in a zero
            // from the bottom clears exactly the next domain.
            rst_out_d = rst_out_q << 1;
            if (N_DOMAINS == 1) begin
              state_d = S_RUN;
              ready_d = 1'b1;
            end else begin
              state_d = S_STAGE;
              stage_d = STG_W'(1);
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_STAGE: begin
          if (cnt_q == GAP_LAST) begin
            cnt_d     = '0;
            rst_out_d = rst_out_q << 1;
            stage_d   = stage_q + 1'b1;
            if (stage_q == STG_LAST) begin
              state_d = S_RUN;
              ready_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_RUN: begin
          rst_out_d = '0;
          ready_d   = 1'b1;
        end
        S_WAIT: begin
          state_d = S_WAIT;
        end
      endcase
    end
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_WAIT;
      cnt_q       <= '0;
      stage_q     <= '0;
      rst_out_q   <= '1;
      ready_q     <= 1'b0;
      soft_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stage_q     <= stage_d;
      rst_out_q   <= rst_out_d;
      ready_q     <= ready_d;
      soft_prev_q <= soft_prev_d;
    end
  end

  assign rst_out   = rst_out_q;
  assign ready     = ready_q;
  assign state_dbg = state_q;

`ifdef PLL_RESET_SEQ_LOCKLOSS_CNT_EN
  logic [LOCKLOSS_CNT_W-1:0] lock_loss_cnt_q, lock_loss_cnt_d;
  logic                      lock_loss_evt;

  // Only real lock losses out of an active state count, never soft requests.
  assign lock_loss_evt = (state_q != S_WAIT) && !locked_s;

  // Saturating increment on each lock-loss transition.
  always_comb begin
    lock_loss_cnt_d = lock_loss_cnt_q;
    if (lock_loss_evt && (lock_loss_cnt_q != '1))
      lock_loss_cnt_d = lock_loss_cnt_q + 1'b1;
  end

  // Lock-loss counter; cleared only by reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) lock_loss_cnt_q <= '0;
    else       lock_loss_cnt_q <= lock_loss_cnt_d;
  end

  assign lock_loss_count = lock_loss_cnt_q;
`else
  assign lock_loss_count = '0;
`endif

endmodule
